stream_serializer: RTL
======================

// Module: stream_serializer
// PURPOSE
//  Transmit-side counterpart of the elastic valid/ready pipeline stage.
//  Accepts one BYTES*8-bit word per upstream handshake and emits it as BYTES
//  consecutive 8-bit beats on a valid/ready stream, with last_out on the final beat.
//  Sits in front of elastic-register chains / byte-wide links.
//  Sustains full throughput: BYTES beats per word, no bubbles between words.
// PARAMETERS
//  BYTES      4   bytes per input word; legal range 1..16
//  MSB_FIRST  0   0: byte 0 = data_in[7:0] is sent first; 1: data_in[BYTES*8-1 -: 8] is sent first
// PORTS
//  clk        in   1          rising-edge clock
//  rst        in   1          reset, asynchronous, active-high
//  data_in    in   BYTES*8    upstream word
//  valid_in   in   1          upstream word valid
//  ready_out  out  1          serializer can accept a word this cycle
//  data_out   out  8          current byte beat
//  valid_out  out  1          data_out/last_out valid
//  ready_in   in   1          downstream accepts the beat this cycle
//  last_out   out  1          current beat is the final byte of the word
// BEHAVIOUR
//  Reset (async, while rst=1): state=IDLE, valid_out=0, data_out=0, last_out=0,
//   byte index=0, held word=0, ready_out=0. Reset asserted mid-word drops the word.
//   No beat of that word appears after rst is released.
//  Handshakes: upstream xfer = valid_in & ready_out; downstream xfer = valid_out & ready_in.
//  FSM, 2 states:
//   IDLE: valid_out=0, ready_out=1.
//    On upstream xfer: latch data_in, idx<=0, go to SEND.
//   SEND: valid_out=1, data_out=selected byte[idx], last_out=(idx==BYTES-1).
//    On downstream xfer with idx<BYTES-1: idx<=idx+1.
//    On downstream xfer with idx==BYTES-1 (last):
//     - upstream xfer in the same cycle: latch new word, idx<=0, stay in SEND.
//     - otherwise: go to IDLE.
//  ready_out is combinational: (state==IDLE) | (state==SEND & last_out & ready_in) while rst=0.
//   It is the only comb. path from ready_in to an output. data_out/valid_out/last_out are registered.
//  Latency: word accepted at edge N -> first beat valid after edge N.
//   That beat can be accepted at edge N+1.
//  Stability: while valid_out=1 & ready_in=0, data_out and last_out hold.
//   valid_out never deasserts without a downstream xfer.
//  Upstream data_in is sampled only on an upstream xfer. Changes at other times are ignored.
//  BYTES=1: every beat is last. With valid_in=ready_in=1 continuously, one word per cycle.
//  Index width: $clog2(BYTES) bits, minimum 1. Index never exceeds BYTES-1. No wrap beyond last.
// TESTING
//  T1 BYTES=4, MSB_FIRST=0, word 32'hDDCCBBAA, ready_in=1 -> beats AA,BB,CC,DD on 4
//     consecutive cycles; last_out only with DD; ready_out=0 during AA..CC.
//  T2 Back-to-back: words 32'h03020100 and 32'h07060504 offered continuously, ready_in=1
//     -> 8 beats 00..07 with no gap; second word accepted in the DD-equivalent (03) cycle.
//  T3 Backpressure: ready_in=0 for 3 cycles while beat BB is presented -> BB, valid_out=1
//     and last_out=0 held stable; sequence then resumes CC,DD.
//  T4 MSB_FIRST=1, word 32'h11223344 -> beats 11,22,33,44, last_out with 44.
//  T5 Reset mid-word: assert rst asynchronously after beat BB
//     -> valid_out, data_out and last_out go to 0 immediately.
//     After release: ready_out=1 and no CC/DD beats appear.
//  T6 BYTES=1, valid_in=ready_in=1 with words 8'h5A, 8'hA5 -> one beat per cycle,
//     last_out=1 on every beat.

Source files
------------

// File: rtl/stream_serializer.sv
// Purpose : splits one BYTES*8-bit word per upstream handshake into BYTES byte beats, last_out on the final beat.
// Latency : word accepted at edge N presents its first beat after edge N; no bubbles between back-to-back words.
// Backpress: beats hold while ready_in=0; ready_out is low while a word is in flight, except in the last-beat cycle when ready_in=1.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   data_in/valid_in    upstream word and its valid
//   ready_out           serializer accepts a word this cycle (combinational from ready_in)
//   data_out/valid_out  registered byte beat and its valid
//   last_out            registered flag marking the final byte of the word
//   ready_in            downstream accepts the beat this cycle
module stream_serializer #(
    parameter int BYTES     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BYTES*8-1:0] data_in,
    input  logic               valid_in,
    output logic               ready_out,
    output logic [7:0]         data_out,
    output logic               valid_out,
    input  logic               ready_in,
    output logic               last_out
);

    localparam int            IW       = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             r_state;
    logic [BYTES*8-1:0] r_word;
    logic [IW-1:0]      r_idx;
    logic [7:0]         r_data;
    logic               r_valid;
    logic               r_last;

    logic               w_up_xfer;
    logic [IW-1:0]      w_idx_nxt;

    // Byte lane selection; the order is fixed at elaboration by MSB_FIRST.
    function automatic logic [7:0] pick(input logic [BYTES*8-1:0] w, input logic [IW-1:0] i);
        logic [7:0] res;
        res = 8'h00;
        for (int b = 0; b < BYTES; b++) begin
            if (int'(i) == b) begin
                res = MSB_FIRST ? w[(BYTES-1-b)*8 +: 8] : w[b*8 +: 8];
            end
        end
        return res;
    endfunction

    // A new word may enter while idle, or in the cycle the last beat leaves,
    // which is what lets back-to-back words run without a bubble.
    assign ready_out = ~rst & ((r_state == IDLE) | ((r_state == SEND) & r_last & ready_in));
    assign w_up_xfer = valid_in & ready_out;
    assign w_idx_nxt = r_idx + 1'b1;

    assign data_out  = r_data;
    assign valid_out = r_valid;
    assign last_out  = r_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_word  <= '0;
            r_idx   <= '0;
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_up_xfer) begin
                        r_word  <= data_in;
                        r_idx   <= '0;
                        r_data  <= pick(data_in, {IW{1'b0}});
                        r_valid <= 1'b1;
                        r_last  <= (LAST_IDX == {IW{1'b0}});
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (ready_in) begin
                        if (!r_last) begin
                            // Only advance while not on the last beat, so the
                            // index can never pass BYTES-1.
                            r_idx  <= w_idx_nxt;
                            r_data <= pick(r_word, w_idx_nxt);
                            r_last <= (w_idx_nxt == LAST_IDX);
                        end else if (w_up_xfer) begin
                            r_word <= data_in;
                            r_idx  <= '0;
                            r_data <= pick(data_in, {IW{1'b0}});
                            r_last <= (LAST_IDX == {IW{1'b0}});
                        end else begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_data  <= 8'h00;
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
